sci_reg_reader: RTL and testbench

//  Read side of the VS10xx SCI serial control bus: issues an SCI READ (opcode 8'h03 + 8-bit

---
 rtl/mp3_sci_pkg.sv | 28 ++
 rtl/sci_clk_tick.sv | 29 ++
 rtl/sci_reg_reader.sv | 147 ++++++++++++++
 tb/tb_sci_reg_reader.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mp3_sci_pkg.sv
// Shared constants for the VS10xx SCI reader/writer pair.
// Holds opcodes, register map, reader state encoding and frame tick landmarks.
package mp3_sci_pkg;

    localparam logic [7:0] SCI_OP_READ     = 8'h03;
    localparam logic [7:0] SCI_OP_WRITE    = 8'h02;

    localparam logic [7:0] SCI_MODE        = 8'h00;
    localparam logic [7:0] SCI_STATUS      = 8'h01;
    localparam logic [7:0] SCI_DECODE_TIME = 8'h04;
    localparam logic [7:0] SCI_HDAT0       = 8'h08;
    localparam logic [7:0] SCI_HDAT1       = 8'h09;
    localparam logic [7:0] SCI_VOL         = 8'h0B;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_DREQ = 3'd1,
        ST_CMD       = 3'd2,
        ST_DATA      = 3'd3,
        ST_TAIL      = 3'd4
    } sci_rd_state_e;

    // Tick numbers within a frame; tick 1 is the one that drops XCS.
    localparam int CMD_LAST_TICK  = 33;
    localparam int DATA_LAST_TICK = 64;
    localparam int FRAME_TICKS    = 66;

endpackage

// File: rtl/sci_clk_tick.sv
// SCLK half-period timebase: one-cycle tick every HALF_PERIOD clocks.
// clr restarts the count so the next tick lands HALF_PERIOD cycles later.
module sci_clk_tick #(
    parameter int HALF_PERIOD = 100
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    output logic tick
);

    localparam int CW = (HALF_PERIOD > 2) ? $clog2(HALF_PERIOD) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(HALF_PERIOD - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sci_reg_reader.sv
// VS10xx SCI register read engine: waits for DREQ, sends {READ, addr},
// then shifts the 16-bit register value in from SO.
module sci_reg_reader #(
    parameter int HALF_PERIOD  = 100,
    parameter int DREQ_TIMEOUT = 16600
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        rd_req,
    input  logic [7:0]  rd_addr,
    input  logic        DREQ,
    input  logic        SO,
    output logic        XCS,
    output logic        SCLK,
    output logic        SI,
    output logic        busy,
    output logic        rd_valid,
    output logic        rd_err,
    output logic [15:0] rd_data
);

    import mp3_sci_pkg::*;

    localparam int WAIT_W = $clog2(DREQ_TIMEOUT + 1);

    sci_rd_state_e state, next_state;

    logic              tick;
    logic [6:0]        tick_num;
    logic [WAIT_W-1:0] wait_cnt;
    logic [15:0]       shift_out;
    logic [15:0]       shift_in;
    logic              wait_expired;

    assign wait_expired = (wait_cnt == WAIT_W'(DREQ_TIMEOUT - 1));

    // Held in reset while idle, so the first tick follows acceptance by HALF_PERIOD cycles.
    sci_clk_tick #(
        .HALF_PERIOD(HALF_PERIOD)
    ) u_tick (
        .CLK  (CLK),
        .RST  (RST),
        .clr  (state == ST_IDLE),
        .tick (tick)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: next_state gets a default before the case so no path can infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (rd_req) next_state = ST_WAIT_DREQ;
            end
            ST_WAIT_DREQ: begin
                if (tick) begin
                    if (DREQ)              next_state = ST_CMD;
                    else if (wait_expired) next_state = ST_IDLE;
                end
            end
            ST_CMD: begin
                if (tick && tick_num == 7'(CMD_LAST_TICK - 1)) next_state = ST_DATA;
            end
            ST_DATA: begin
                if (tick && tick_num == 7'(DATA_LAST_TICK - 1)) next_state = ST_TAIL;
            end
            ST_TAIL: begin
                if (tick && tick_num == 7'(FRAME_TICKS - 1)) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        XCS  = !(state inside {ST_CMD, ST_DATA, ST_TAIL});
        busy = (state != ST_IDLE);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            SCLK      <= 1'b0;
            SI        <= 1'b0;
            rd_valid  <= 1'b0;
            rd_err    <= 1'b0;
            rd_data   <= '0;
            tick_num  <= '0;
            wait_cnt  <= '0;
            shift_out <= '0;
            shift_in  <= '0;
        end else begin
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rd_req) begin
                        shift_out <= {SCI_OP_READ, rd_addr};
                        wait_cnt  <= '0;
                    end
                end
                ST_WAIT_DREQ: begin
                    if (tick) begin
                        if (DREQ) begin
                            SI       <= shift_out[15];
                            tick_num <= 7'd1;
                        end else if (wait_expired) begin
                            rd_err <= 1'b1;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                end
                ST_CMD, ST_DATA: begin
                    if (tick) begin
                        tick_num <= tick_num + 7'd1;
                        SCLK     <= !SCLK;
                        // Zero fill makes SI fall to 0 after the last command bit.
                        if (SCLK) begin
                            SI        <= shift_out[14];
                            shift_out <= {shift_out[14:0], 1'b0};
                        end else if (state == ST_DATA) begin
                            shift_in <= {shift_in[14:0], SO};
                        end
                    end
                end
                ST_TAIL: begin
                    if (tick) begin
                        tick_num <= tick_num + 7'd1;
                        SCLK     <= 1'b0;
                        if (tick_num == 7'(FRAME_TICKS - 1)) begin
                            rd_data  <= shift_in;
                            rd_valid <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sci_reg_reader.sv
// Bench for sci_reg_reader: VS10xx SCI responder model plus directed and random reads.
// Expected timing and data come from frame-level arithmetic, not from the RTL structure.
module tb_sci_reg_reader;

    import mp3_sci_pkg::*;

    localparam int HP = 2;
    localparam int TO = 8;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        rd_req = 1'b0;
    logic [7:0]  rd_addr = '0;
    logic        DREQ = 1'b1;
    logic        SO = 1'b0;
    logic        XCS, SCLK, SI, busy, rd_valid, rd_err;
    logic [15:0] rd_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] exp_data = '0;

    // Responder state
    logic [15:0] resp_val = '0;
    logic [15:0] cmd_seen = '0;
    int          frames   = 0;
    int          rise_cnt = 0;
    bit          si_tail_bad = 1'b0;

    always #5 CLK = ~CLK;

    sci_reg_reader #(
        .HALF_PERIOD  (HP),
        .DREQ_TIMEOUT (TO)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .DREQ     (DREQ),
        .SO       (SO),
        .XCS      (XCS),
        .SCLK     (SCLK),
        .SI       (SI),
        .busy     (busy),
        .rd_valid (rd_valid),
        .rd_err   (rd_err),
        .rd_data  (rd_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // SO carries the inverted bit until one CLK after SCLK falls, so only a
    // sample taken at the rising edge sees the true bit.
    always begin
        @(negedge XCS);
        frames++;
        rise_cnt    = 0;
        cmd_seen    = '0;
        si_tail_bad = 1'b0;
        while (!XCS) begin
            @(posedge SCLK or negedge SCLK or posedge XCS);
            if (XCS) break;
            if (SCLK) begin
                rise_cnt++;
                if (rise_cnt <= 16) cmd_seen = {cmd_seen[14:0], SI};
                else if (SI)        si_tail_bad = 1'b1;
            end else if (rise_cnt >= 16 && rise_cnt < 32) begin
                SO = ~resp_val[31 - rise_cnt];
                @(posedge CLK);
                #1;
                SO = resp_val[31 - rise_cnt];
            end
        end
        SO = 1'b0;
    end

    // Starts right after a clock edge with busy low; returns #1 after the pulse edge.
    task automatic do_read(input logic [7:0] addr, input logic [15:0] val, input int n_low,
                           input bit hold_req, input bit toggle);
        int cyc, xcs_cyc, frames0;
        bit got_v, got_e, busy_drop;
        resp_val = val;
        frames0  = frames;
        rd_addr  = addr;
        rd_req   = 1'b1;
        DREQ     = (n_low == 0);
        @(posedge CLK);
        #1;
        if (hold_req) rd_addr = addr ^ 8'h5A;
        else          rd_req  = 1'b0;
        check("busy_on_accept", busy, 1);
        cyc = 0; xcs_cyc = -1; got_v = 0; got_e = 0; busy_drop = 0;
        while (!got_v && !got_e && cyc < 400) begin
            @(posedge CLK);
            #1;
            cyc++;
            if (n_low > 0 && cyc == HP * n_low) DREQ = 1'b1;
            if (xcs_cyc < 0 && !XCS) xcs_cyc = cyc;
            if (toggle && xcs_cyc >= 0) DREQ = 1'($urandom_range(0, 1));
            got_v = rd_valid;
            got_e = rd_err;
            if (!got_v && !got_e && !busy) busy_drop = 1'b1;
        end
        rd_req = 1'b0;
        DREQ   = 1'b1;
        check("pulse_excl", 32'(got_v & got_e), 0);
        check("busy_held", busy_drop, 0);
        check("busy_low", busy, 0);
        if (n_low >= TO) begin
            check("err_seen", got_e, 1);
            check("err_cycle", cyc, HP * TO);
            check("err_xcs_idle", xcs_cyc, -1);
            check("err_frames", frames - frames0, 0);
            check("err_data_kept", rd_data, exp_data);
        end else begin
            exp_data = val;
            check("valid_seen", got_v, 1);
            check("valid_cycle", cyc, HP * (FRAME_TICKS + n_low));
            check("xcs_fall", xcs_cyc, HP * (n_low + 1));
            check("rd_data", rd_data, exp_data);
            check("cmd_si", cmd_seen, {SCI_OP_READ, addr});
            check("si_tail_zero", si_tail_bad, 0);
            check("rise_count", rise_cnt, 32);
            check("frames", frames - frames0, 1);
        end
    endtask

    initial begin
        int f0, cyc, n_low;
        bit tog;
        logic [7:0]  a;
        logic [15:0] v;

        repeat (3) @(posedge CLK);
        #1;
        check("rst_xcs", XCS, 1);
        check("rst_sclk", SCLK, 0);
        check("rst_busy", busy, 0);
        check("rst_data", rd_data, 0);
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;

        // Basic read of DECODE_TIME
        do_read(SCI_DECODE_TIME, 16'h1234, 0, 0, 0);

        // Request held high with another address: single frame, nothing queued
        f0 = frames;
        do_read(SCI_HDAT0, 16'hBEEF, 0, 1, 0);
        repeat (20) @(posedge CLK);
        #1;
        check("no_requeue_frames", frames, f0 + 1);
        check("no_requeue_busy", busy, 0);

        // DREQ low for three ticks
        do_read(SCI_HDAT1, 16'h5A3C, 3, 0, 0);

        // DREQ never rises: timeout
        do_read(SCI_VOL, 16'h7777, TO + 2, 0, 0);

        // Reset asserted right after rising edge 20
        resp_val = 16'hA5C3;
        rd_addr  = SCI_STATUS;
        rd_req   = 1'b1;
        f0       = frames;
        @(posedge CLK);
        #1;
        rd_req = 1'b0;
        cyc = 0;
        while (!(frames == f0 + 1 && rise_cnt == 20) && cyc < 200) begin
            @(posedge CLK);
            #1;
            cyc++;
        end
        check("rst_reached_edge20", 32'(cyc < 200), 1);
        RST = 1'b0;
        #1;
        exp_data = '0;
        check("midrst_xcs", XCS, 1);
        check("midrst_sclk", SCLK, 0);
        check("midrst_si", SI, 0);
        check("midrst_busy", busy, 0);
        check("midrst_valid", rd_valid, 0);
        check("midrst_err", rd_err, 0);
        check("midrst_data", rd_data, exp_data);
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        do_read(SCI_STATUS, 16'h8C41, 0, 0, 0);

        // Back-to-back with DREQ toggling mid-frame
        do_read(SCI_HDAT0, 16'hFFFF, 0, 0, 1);
        do_read(SCI_HDAT1, 16'h0001, 0, 0, 1);

        // Random reads, some ending in timeout
        for (int i = 0; i < 12; i++) begin
            int r;
            a = 8'($urandom);
            v = 16'($urandom);
            r = $urandom_range(0, 9);
            n_low = (r >= 7) ? TO + r - 7 : r % 4;
            tog = 1'($urandom_range(0, 1));
            do_read(a, v, n_low, 0, tog);
        end

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
